// File: rtl/spi_controller.sv
// SPI mode-0 write controller: 16-bit frame {rw_n, addr[6:0], wdata[7:0]}, MSB first.
// Optional read support is compiled in when SPI_CONTROLLER_READ_EN is defined.
module spi_controller #(
    parameter int unsigned HALF_PERIOD = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [6:0] addr,
    input  logic [7:0] wdata,
`ifdef SPI_CONTROLLER_READ_EN
    input  logic       rw,
    input  logic       cipo,
    output logic [7:0] rdata,
`endif
    output logic       busy,
    output logic       done,
    output logic       sclk,
    output logic       ncs,
    output logic       copi
);

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StShift,
        StHold,
        StGap
    } state_e;

    localparam logic [7:0] HpLast = 8'(HALF_PERIOD - 1);

    state_e      state_q, state_d;
    logic [7:0]  hp_cnt_q, hp_cnt_d;
    logic [4:0]  edge_cnt_q, edge_cnt_d;
    logic [15:0] frame_q, frame_d;
    logic        sclk_q, sclk_d;
    logic        done_q, done_d;
    logic        hp_last;
    logic        rw_n;

`ifdef SPI_CONTROLLER_READ_EN
    logic       rd_q, rd_d;
    logic [7:0] rx_q, rx_d;
    logic [7:0] rdata_q, rdata_d;
    assign rw_n  = ~rw;
    assign rdata = rdata_q;
`else
    assign rw_n = 1'b1;
`endif

    assign hp_last = (hp_cnt_q == HpLast);

    // Next-state logic for the frame sequencer, counters and shift register
    always_comb begin
        state_d    = state_q;
        hp_cnt_d   = hp_cnt_q;
        edge_cnt_d = edge_cnt_q;
        frame_d    = frame_q;
        sclk_d     = sclk_q;
        done_d     = 1'b0;
`ifdef SPI_CONTROLLER_READ_EN
        rd_d       = rd_q;
        rx_d       = rx_q;
        rdata_d    = rdata_q;
`endif
        unique case (state_q)
            StIdle: begin
                hp_cnt_d   = '0;
                edge_cnt_d = '0;
                sclk_d     = 1'b0;
                if (start) begin
                    frame_d = {rw_n, addr, wdata};
                    state_d = StSetup;
`ifdef SPI_CONTROLLER_READ_EN
                    rd_d    = rw;
                    rx_d    = '0;
`endif
                end
            end
            StSetup: begin
                if (hp_last) begin
                    hp_cnt_d = '0;
                    state_d  = StShift;
                end else begin
                    hp_cnt_d = hp_cnt_q + 8'd1;
                end
            end
            StShift: begin
                if (hp_last) begin
                    hp_cnt_d = '0;
                    if (!sclk_q) begin
                        // Rising edge: copi is held, peripheral data is sampled
                        sclk_d     = 1'b1;
                        edge_cnt_d = edge_cnt_q + 5'd1;
`ifdef SPI_CONTROLLER_READ_EN
                        if (edge_cnt_q >= 5'd8) begin
                            rx_d = {rx_q[6:0], cipo};
                        end
`endif
                    end else begin
                        // Falling edge: advance copi, or finish after the 16th bit
                        sclk_d = 1'b0;
                        if (edge_cnt_q == 5'd16) begin
                            state_d = StHold;
                        end else begin
                            frame_d = {frame_q[14:0], 1'b0};
                        end
                    end
                end else begin
                    hp_cnt_d = hp_cnt_q + 8'd1;
                end
            end
            StHold: begin
                if (hp_last) begin
                    hp_cnt_d = '0;
                    state_d  = StGap;
                end else begin
                    hp_cnt_d = hp_cnt_q + 8'd1;
                end
            end
            StGap: begin
                if (hp_last) begin
                    hp_cnt_d   = '0;
                    edge_cnt_d = '0;
                    done_d     = 1'b1;
                    state_d    = StIdle;
`ifdef SPI_CONTROLLER_READ_EN
                    if (rd_q) begin
                        rdata_d = rx_q;
                    end
`endif
                end else begin
                    hp_cnt_d = hp_cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and datapath registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            hp_cnt_q   <= '0;
            edge_cnt_q <= '0;
            frame_q    <= '0;
            sclk_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef SPI_CONTROLLER_READ_EN
            rd_q       <= 1'b0;
            rx_q       <= '0;
            rdata_q    <= '0;
`endif
        end else begin
            state_q    <= state_d;
            hp_cnt_q   <= hp_cnt_d;
            edge_cnt_q <= edge_cnt_d;
            frame_q    <= frame_d;
            sclk_q     <= sclk_d;
            done_q     <= done_d;
`ifdef SPI_CONTROLLER_READ_EN
            rd_q       <= rd_d;
            rx_q       <= rx_d;
            rdata_q    <= rdata_d;
`endif
        end
    end

    // Outputs decoded from registered state so reset takes effect immediately
    always_comb begin
        busy = (state_q != StIdle);
        ncs  = !((state_q == StSetup) || (state_q == StShift) || (state_q == StHold));
        copi = ncs ? 1'b0 : frame_q[15];
        sclk = sclk_q;
        done = done_q;
    end

endmodule

// File: tb/tb_spi_controller.sv
// Directed, table-driven bench for spi_controller (HALF_PERIOD=2 and =1 instances).
module tb_spi_controller;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       start_h2, start_h1;
    logic [6:0] addr;
    logic [7:0] wdata;
    logic       sel_h1;
    logic       busy_h2, done_h2, sclk_h2, ncs_h2, copi_h2;
    logic       busy_h1, done_h1, sclk_h1, ncs_h1, copi_h1;
`ifdef SPI_CONTROLLER_READ_EN
    logic       rw, cipo;
    logic [7:0] rdata_h2, rdata_h1;
`endif

    spi_controller #(.HALF_PERIOD(2)) dut_h2 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start_h2),
        .addr  (addr),
        .wdata (wdata),
`ifdef SPI_CONTROLLER_READ_EN
        .rw    (rw),
        .cipo  (cipo),
        .rdata (rdata_h2),
`endif
        .busy  (busy_h2),
        .done  (done_h2),
        .sclk  (sclk_h2),
        .ncs   (ncs_h2),
        .copi  (copi_h2)
    );

    spi_controller #(.HALF_PERIOD(1)) dut_h1 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start_h1),
        .addr  (addr),
        .wdata (wdata),
`ifdef SPI_CONTROLLER_READ_EN
        .rw    (rw),
        .cipo  (cipo),
        .rdata (rdata_h1),
`endif
        .busy  (busy_h1),
        .done  (done_h1),
        .sclk  (sclk_h1),
        .ncs   (ncs_h1),
        .copi  (copi_h1)
    );

    logic busy_s, done_s, sclk_s, ncs_s, copi_s;
    assign busy_s = sel_h1 ? busy_h1 : busy_h2;
    assign done_s = sel_h1 ? done_h1 : done_h2;
    assign sclk_s = sel_h1 ? sclk_h1 : sclk_h2;
    assign ncs_s  = sel_h1 ? ncs_h1  : ncs_h2;
    assign copi_s = sel_h1 ? copi_h1 : copi_h2;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic set_start(input logic v);
        if (sel_h1) start_h1 = v;
        else start_h2 = v;
    endtask

    typedef struct {
        int          hp;
        logic [6:0]  a;
        logic [7:0]  d;
        logic [15:0] bits;
        int          done_cyc;
        int          poke;
    } vec_t;

    // Cycle 0 is the cycle in which start is sampled; cycle 1 is SETUP.
    task automatic run_frame(input vec_t v, input logic rd);
        int         cyc, rises, ndone, done_at, run, bad_copi, bad_lvl;
        logic [15:0] bits;
        logic       prev_sclk, prev_copi;
        logic [7:0] model;
        model    = 8'h3C;
        sel_h1   = (v.hp == 1);
        @(negedge clk);
        addr     = v.a;
        wdata    = v.d;
`ifdef SPI_CONTROLLER_READ_EN
        rw       = rd;
        cipo     = 1'b0;
`endif
        set_start(1'b1);
        cyc = 0; rises = 0; ndone = 0; done_at = -1; run = 0; bad_copi = 0; bad_lvl = 0;
        bits = '0; prev_sclk = 1'b0; prev_copi = 1'b0;
        while (cyc < v.done_cyc + 3 && cyc < 300) begin
            @(posedge clk);
            #1;
            cyc++;
            if (cyc == 1) begin
                set_start(1'b0);
                check("setup_ncs", {31'd0, ncs_s}, 32'd0);
                check("setup_busy", {31'd0, busy_s}, 32'd1);
                check("setup_copi", {31'd0, copi_s}, {31'd0, v.bits[15]});
                addr  = ~v.a;
                wdata = ~v.d;
`ifdef SPI_CONTROLLER_READ_EN
                rw    = ~rd;
`endif
            end
            if (v.poke != 0 && cyc == v.poke) set_start(1'b1);
            if (v.poke != 0 && cyc == v.poke + 1) set_start(1'b0);
            if (sclk_s != prev_sclk) begin
                if (rises > 0 && run != v.hp) bad_lvl++;
                run = 1;
            end else begin
                run++;
            end
            if (sclk_s && !prev_sclk) begin
                bits = {bits[14:0], copi_s};
                rises++;
            end
            if (copi_s !== prev_copi && !ncs_s && cyc > 1 && !(prev_sclk && !sclk_s)) bad_copi++;
            if (done_s) begin
                ndone++;
                if (done_at < 0) done_at = cyc;
                check("done_busy", {31'd0, busy_s}, 32'd0);
`ifdef SPI_CONTROLLER_READ_EN
                if (rd) check("rdata", {24'd0, sel_h1 ? rdata_h1 : rdata_h2}, 32'h3C);
`endif
            end
            prev_sclk = sclk_s;
            prev_copi = copi_s;
`ifdef SPI_CONTROLLER_READ_EN
            cipo = (rises >= 8 && rises < 16) ? model[15 - rises] : 1'b0;
`endif
        end
        check("rises", rises, 16);
        check("bits", {16'd0, bits}, {16'd0, v.bits});
        check("done_cycle", done_at, v.done_cyc);
        check("done_count", ndone, 1);
        check("copi_stable", bad_copi, 0);
        check("sclk_level_len", bad_lvl, 0);
        check("end_ncs", {31'd0, ncs_s}, 32'd1);
        check("end_idle", {29'd0, busy_s, sclk_s, copi_s}, 32'd0);
    endtask

    vec_t vecs[7];

    initial begin
        int cyc, ndone, d1, d2, hi_run, min_gap, rises;
        logic [15:0] bits, f1, f2;
        logic saw_low, prev_sclk;

        vecs[0] = '{2, 7'h04, 8'hA5, 16'h84A5, 71, 0};
        vecs[1] = '{2, 7'h7F, 8'hFF, 16'hFFFF, 71, 0};
        vecs[2] = '{2, 7'h00, 8'h00, 16'h8000, 71, 0};
        vecs[3] = '{2, 7'h55, 8'h3C, 16'hD53C, 71, 0};
        vecs[4] = '{2, 7'h2A, 8'hC3, 16'hAAC3, 71, 20};
        vecs[5] = '{1, 7'h7F, 8'hFF, 16'hFFFF, 36, 0};
        vecs[6] = '{1, 7'h04, 8'hA5, 16'h84A5, 36, 0};

        rst_n = 1'b0; start_h2 = 1'b0; start_h1 = 1'b0; addr = '0; wdata = '0; sel_h1 = 1'b0;
`ifdef SPI_CONTROLLER_READ_EN
        rw = 1'b0; cipo = 1'b0;
`endif
        #1;
        check("rst_h2", {27'd0, ncs_h2, sclk_h2, copi_h2, busy_h2, done_h2}, 32'h10);
        check("rst_h1", {27'd0, ncs_h1, sclk_h1, copi_h1, busy_h1, done_h1}, 32'h10);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) run_frame(vecs[i], 1'b0);

        // Back-to-back: start held through two frames
        sel_h1 = 1'b0;
        @(negedge clk);
        addr = 7'h00; wdata = 8'h00; start_h2 = 1'b1;
        cyc = 0; ndone = 0; d1 = 0; d2 = 0; hi_run = 0; min_gap = 999; saw_low = 1'b0;
        bits = '0; f1 = '0; f2 = '0; prev_sclk = 1'b0;
        while (ndone < 2 && cyc < 400) begin
            @(posedge clk);
            #1;
            cyc++;
            if (cyc == 1) addr = 7'h01;
            if (sclk_s && !prev_sclk) bits = {bits[14:0], copi_s};
            prev_sclk = sclk_s;
            if (ncs_s) begin
                hi_run++;
            end else begin
                if (saw_low && hi_run > 0 && hi_run < min_gap) min_gap = hi_run;
                hi_run  = 0;
                saw_low = 1'b1;
            end
            if (done_s) begin
                ndone++;
                if (ndone == 1) begin f1 = bits; d1 = cyc; end
                else begin f2 = bits; d2 = cyc; end
                bits = '0;
            end
            if (ndone == 1 && cyc == d1 + 1) start_h2 = 1'b0;
        end
        start_h2 = 1'b0;
        check("b2b_done_count", ndone, 2);
        check("b2b_frame1", {16'd0, f1}, 32'h8000);
        check("b2b_frame2", {16'd0, f2}, 32'h8100);
        check("b2b_spacing", d2 - d1, 71);
        check("b2b_gap_ge3", {31'd0, min_gap >= 3}, 32'd1);
        repeat (5) @(posedge clk);
        #1;
        check("b2b_idle_after", {31'd0, busy_s}, 32'd0);

        // Reset abort at the 8th sclk rise
        sel_h1 = 1'b0;
        @(negedge clk);
        addr = 7'h04; wdata = 8'hA5; start_h2 = 1'b1;
        cyc = 0; rises = 0; prev_sclk = 1'b0;
        while (rises < 8 && cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
            if (cyc == 1) start_h2 = 1'b0;
            if (sclk_s && !prev_sclk) rises++;
            prev_sclk = sclk_s;
        end
        check("abort_reached_rise8", rises, 8);
        rst_n = 1'b0;
        #1;
        check("abort_outputs", {27'd0, ncs_s, sclk_s, copi_s, busy_s, done_s}, 32'h10);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 80; i++) begin
            @(posedge clk);
            #1;
            if (done_s || !ncs_s) ndone++;
        end
        check("abort_no_done", ndone, 0);
        run_frame(vecs[0], 1'b0);

`ifdef SPI_CONTROLLER_READ_EN
        run_frame('{2, 7'h02, 8'h5A, 16'h025A, 71, 0}, 1'b1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/spi_controller.md
SPI_CONTROLLER -- requirements
Module: spi_controller

Interface
REQ-001 SHALL have parameter HALF_PERIOD, default 2, meaning the number of clk cycles per SCLK half-period; legal range 1..255.
REQ-002 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start  input  1  request one frame; sampled only while busy=0.
REQ-005 SHALL have port addr  input  7  register address, captured on start acceptance.
REQ-006 SHALL have port wdata  input  8  write data, captured on start acceptance.
REQ-007 SHALL have port busy  output  1  high from the cycle after acceptance until done.
REQ-008 SHALL have port done  output  1  one-cycle pulse at end of frame.
REQ-009 SHALL have port sclk  output  1  SPI clock, mode 0 (idle low).
REQ-010 SHALL have port ncs  output  1  active-low chip select.
REQ-011 SHALL have port copi  output  1  serial data to the peripheral.

Function
REQ-012 SHALL build a 16-bit frame {rw_n, addr[6:0], wdata[7:0]} and shift it MSB first; rw_n=1 means write.
REQ-013 SHALL implement states IDLE -> SETUP -> SHIFT -> HOLD -> GAP -> IDLE.
REQ-014 SHALL accept start in IDLE at clk edge T0, capture the frame, and drive ncs=0, busy=1, copi=frame[15] from T0+1 (SETUP).
REQ-015 SHALL stay in SETUP for HALF_PERIOD cycles with sclk=0, then enter SHIFT.
REQ-016 SHALL in SHIFT toggle sclk every HALF_PERIOD cycles, producing exactly 16 rising edges; copi changes only on sclk falling transitions and is stable across each rising edge.
REQ-017 SHALL after the 16th falling edge hold sclk=0, ncs=0 for HALF_PERIOD cycles (HOLD), then drive ncs=1 and copi=0.
REQ-018 SHALL keep ncs=1 for HALF_PERIOD cycles (GAP), then return to IDLE, asserting done=1 and busy=0 in that same cycle.
REQ-019 SHALL make start-accept to done exactly 1+35*HALF_PERIOD clk cycles (71 at default).
REQ-020 SHALL accept a start presented in the done cycle (back-to-back), guaranteeing ncs high for at least HALF_PERIOD+1 cycles between frames.
REQ-021 SHALL ignore start while busy=1; addr/wdata changes during a frame SHALL NOT affect it.
REQ-022 SHALL use a half-period counter and 5-bit edge counter that never wrap during a frame; both clear on entering IDLE.

Reset
REQ-023 SHALL on rst_n=0 immediately force ncs=1, sclk=0, copi=0, busy=0, done=0, state IDLE, counters 0 (and rdata=0 when compiled in).
REQ-024 SHALL on reset mid-frame abort without a done pulse; the first start after rst_n rises SHALL begin a complete new frame.

Configuration
REQ-025 SHALL, when macro SPI_CONTROLLER_READ_EN is defined, add ports rw (input 1, 1=read), cipo (input 1) and rdata (output 8), set rw_n=~rw, sample cipo on the rising sclk edges of bits 7..0 and update rdata in the done cycle for read frames only.
REQ-026 SHALL, without SPI_CONTROLLER_READ_EN, omit rw/cipo/rdata and fix rw_n=1 (write-only).

Verification
REQ-027 SHALL verify write: HALF_PERIOD=2, addr=7'h04, wdata=8'hA5, start pulse -> copi bits 1000_0100_1010_0101 on 16 sclk rises, done at cycle 71.
REQ-028 SHALL verify back-to-back: start held high through two frames (addr 0 then 1) -> two complete frames, ncs high >=3 cycles between, two done pulses.
REQ-029 SHALL verify ignored start: start pulse at cycle 20 of a frame -> no effect, one done only.
REQ-030 SHALL verify reset abort: rst_n low at sclk rise 8 -> ncs=1, sclk=0 same cycle, no done; next frame clean.
REQ-031 SHALL verify HALF_PERIOD=1: addr=7'h7F, wdata=8'hFF -> 16 rises, each sclk level lasts 1 cycle, done at cycle 36.
REQ-032 SHALL verify read (SPI_CONTROLLER_READ_EN): rw=1, addr=7'h02, cipo model returns 8'h3C -> frame[15]=0, rdata=8'h3C at done.
